// File: rtl/alu_leg_arbiter_if.sv
// rtl/alu_leg_arbiter_if.sv - requester, response and ALU-side signal bundle for alu_leg_arbiter
interface alu_leg_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_in1;
    logic [N_REQ*DATA_W-1:0] req_in2;
    logic [N_REQ*8-1:0]      req_op;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;

    logic [DATA_W-1:0]       alu_in1;
    logic [DATA_W-1:0]       alu_in2;
    logic [7:0]              alu_op;
    logic [DATA_W-1:0]       alu_out;

    // master: requesters, response consumer and the ALU itself
    modport master (
        output req_valid, req_in1, req_in2, req_op, rsp_ready, alu_out,
        input  req_ready, rsp_valid, rsp_id, rsp_data, alu_in1, alu_in2, alu_op
    );

    modport slave (
        input  req_valid, req_in1, req_in2, req_op, rsp_ready, alu_out,
        output req_ready, rsp_valid, rsp_id, rsp_data, alu_in1, alu_in2, alu_op
    );
endinterface

// File: rtl/alu_leg_arbiter.sv
// rtl/alu_leg_arbiter.sv - round-robin sharing of one combinational LEG ALU; ALU_ARB_FIXED_PRIO_EN selects fixed priority
module alu_leg_arbiter #(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = 8,
    parameter int MUL_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    alu_leg_arbiter_if.slave   bus
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   rsp_id_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [DATA_W-1:0] alu_in1_q;
    logic [DATA_W-1:0] alu_in2_q;
    logic [7:0]        alu_op_q;

    logic              found;
    logic [ID_W-1:0]   grant;
    int                scan_idx;
    logic [DATA_W-1:0] grant_in1;
    logic [DATA_W-1:0] grant_in2;
    logic [7:0]        grant_op;

    // Scan from rr_ptr upward with wrap. In fixed-priority builds rr_ptr never
    // leaves 0, so the same scan yields the lowest-index valid requester.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        scan_idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && bus.req_valid[ID_W'(scan_idx)]) begin
                found = 1'b1;
                grant = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        grant_in1 = '0;
        grant_in2 = '0;
        grant_op  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == grant) begin
                grant_in1 = bus.req_in1[k*DATA_W +: DATA_W];
                grant_in2 = bus.req_in2[k*DATA_W +: DATA_W];
                grant_op  = bus.req_op[k*8 +: 8];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (!rst && state == IDLE && found)
            bus.req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            alu_in1_q  <= '0;
            alu_in2_q  <= '0;
            alu_op_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        alu_in1_q <= grant_in1;
                        alu_in2_q <= grant_in2;
                        alu_op_q  <= grant_op;
                        rsp_id_q  <= grant;
                        cnt       <= grant_op[3] ? CNT_W'(MUL_LATENCY - 1) : '0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands stay on the ALU until the last EXEC cycle samples its output.
                    if (cnt == '0) begin
                        rsp_data_q <= bus.alu_out;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        rr_ptr <= (rsp_id_q == ID_W'(N_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.alu_in1   = alu_in1_q;
    assign bus.alu_in2   = alu_in2_q;
    assign bus.alu_op    = alu_op_q;
endmodule

// File: tb/tb_alu_leg_arbiter.sv
// tb/tb_alu_leg_arbiter.sv - self-checking bench for alu_leg_arbiter
module tb_alu_leg_arbiter;
    localparam int N  = 2;
    localparam int W  = 8;
    localparam int ML = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_leg_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

    alu_leg_arbiter #(.N_REQ(N), .DATA_W(W), .MUL_LATENCY(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ALU stand-in: op[3] selects the multiplier, otherwise add; low byte kept
    always_comb begin
        if (bus.alu_op[3]) bus.alu_out = 8'(bus.alu_in1 * bus.alu_in2);
        else               bus.alu_out = 8'(bus.alu_in1 + bus.alu_in2);
    end

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        int         exp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int alu_ref(input int a, input int b, input int op);
        return ((op & 8) != 0) ? ((a * b) & 255) : ((a + b) & 255);
    endfunction

    function automatic int lat_ref(input int op);
        return ((op & 8) != 0) ? ML + 1 : 2;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int base);
        for (int k = 0; k < N; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            if (v[k]) return k;
`else
            if (v[(base + k) % N]) return (base + k) % N;
`endif
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        bus.req_in1[i*W +: W] = a;
        bus.req_in2[i*W +: W] = b;
        bus.req_op[i*8 +: 8]  = op;
    endtask

    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input int expd);
        int c;
        set_req(id, a, b, op);
        bus.req_valid     = '0;
        bus.req_valid[id] = 1'b1;
        #1;
        chk("tbl_ready", int'(bus.req_ready), 1 << id);
        tick();
        bus.req_valid = '0;
        c = 1;
        chk("tbl_alu_in1", int'(bus.alu_in1), int'(a));
        while (!bus.rsp_valid && c < 20) begin
            tick();
            c++;
        end
        chk("tbl_latency", c, lat_ref(int'(op)));
        chk("tbl_data", int'(bus.rsp_data), expd);
        chk("tbl_id", int'(bus.rsp_id), id);
        chk("tbl_alu_op_held", int'(bus.alu_op), int'(op));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("tbl_rsp_cleared", int'(bus.rsp_valid), 0);
    endtask

    initial begin
        int c;
        int ng;
        int last;
        int q[$];
        int exp_seq[4];
        logic       pend[N];
        logic [7:0] p1[N];
        logic [7:0] p2[N];
        logic [7:0] pop[N];
        logic       busy;
        int         resp_cyc;
        int         exp_data;
        int         exp_id;
        int         rr_m;
        int         g;
        logic [N-1:0] exp_ready;

        tbl[0] = '{0, 8'd3,   8'd4,   8'h00, 7};
        tbl[1] = '{1, 8'd5,   8'd6,   8'h08, 30};
        tbl[2] = '{0, 8'd200, 8'd100, 8'h00, 44};
        tbl[3] = '{1, 8'd16,  8'd17,  8'h08, 16};
        tbl[4] = '{1, 8'd255, 8'd1,   8'h00, 0};
        tbl[5] = '{0, 8'd255, 8'd255, 8'h08, 1};

        bus.req_valid = '0;
        bus.req_in1   = '0;
        bus.req_in2   = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;

        // Reset held two cycles, with requests pending to show req_ready stays low
        tick();
        bus.req_valid = '1;
        set_req(0, 8'd1, 8'd1, 8'h00);
        #1;
        chk("rst_req_ready", int'(bus.req_ready), 0);
        tick();
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_id", int'(bus.rsp_id), 0);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        chk("rst_alu_in1", int'(bus.alu_in1), 0);
        chk("rst_alu_in2", int'(bus.alu_in2), 0);
        chk("rst_alu_op", int'(bus.alu_op), 0);
        bus.req_valid = '0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].exp);

        // Response stall: five cycles with rsp_ready low while req1 waits
        set_req(0, 8'd9, 8'd10, 8'h00);
        set_req(1, 8'd2, 8'd7, 8'h08);
        bus.req_valid = 2'b01;
        #1;
        chk("stall_ready", int'(bus.req_ready), 1);
        tick();
        bus.req_valid = '0;
        c = 0;
        while (!bus.rsp_valid && c < 20) begin
            tick();
            c++;
        end
        bus.req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_rsp_valid", int'(bus.rsp_valid), 1);
            chk("stall_rsp_data", int'(bus.rsp_data), 19);
            chk("stall_rsp_id", int'(bus.rsp_id), 0);
            chk("stall_req_ready", int'(bus.req_ready), 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("stall_next_grant", int'(bus.req_ready), 2);
        tick();
        bus.req_valid = '0;
        c = 0;
        while (!bus.rsp_valid && c < 20) begin
            tick();
            c++;
        end
        chk("stall_next_data", int'(bus.rsp_data), 14);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Reset during EXEC of a mul drops it and rewinds the pointer
        set_req(1, 8'd5, 8'd6, 8'h08);
        bus.req_valid = 2'b10;
        #1;
        chk("rstx_ready", int'(bus.req_ready), 2);
        tick();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        bus.req_valid = 2'b11;
        #1;
        chk("rstx_ready_in_rst", int'(bus.req_ready), 0);
        bus.req_valid = '0;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstx_no_rsp", int'(bus.rsp_valid), 0);
        end

        // Both requesters valid continuously with the consumer always ready
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        set_req(0, 8'd1, 8'd2, 8'h00);
        set_req(1, 8'd3, 8'd4, 8'h00);
        bus.req_valid = 2'b11;
        #1;
        ng   = 0;
        last = 0;
        for (int cy = 0; cy < 30 && ng < 4; cy++) begin
            if (bus.rsp_valid) begin
                if (q.size() > 0) chk("rot_rsp_id", int'(bus.rsp_id), q.pop_front());
                else              chk("rot_spurious_rsp", 1, 0);
            end
            if (bus.req_ready != '0) begin
                chk("rot_grant", int'(bus.req_ready), 1 << exp_seq[ng]);
                if (ng > 0) chk("rot_spacing", cy - last, 3);
                q.push_back(exp_seq[ng]);
                last = cy;
                ng++;
            end
            tick();
        end
        if (ng < 4) chk("rot_timeout", ng, 4);
        bus.req_valid = '0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rsp_valid) begin
                if (q.size() > 0) chk("rot_rsp_id", int'(bus.rsp_id), q.pop_front());
                else              chk("rot_spurious_rsp", 1, 0);
            end
            tick();
        end
        chk("rot_all_responded", q.size(), 0);

        // Randomized traffic against a transaction-level model
        rr_m = 0;
        busy = 1'b0;
        resp_cyc = 0;
        exp_data = 0;
        exp_id = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    p1[i]   = 8'($urandom);
                    p2[i]   = 8'($urandom);
                    pop[i]  = ($urandom_range(0, 1) == 1) ? 8'h08 : 8'h00;
                end
                bus.req_valid[i] = pend[i];
                set_req(i, p1[i], p2[i], pop[i]);
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = '0;
            g = -1;
            if (!busy) begin
                g = pick(bus.req_valid, rr_m);
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            chk("rand_req_ready", int'(bus.req_ready), int'(exp_ready));
            chk("rand_rsp_valid", int'(bus.rsp_valid), (busy && t >= resp_cyc) ? 1 : 0);
            if (busy && t >= resp_cyc) begin
                chk("rand_rsp_data", int'(bus.rsp_data), exp_data);
                chk("rand_rsp_id", int'(bus.rsp_id), exp_id);
            end
            if (g >= 0) begin
                busy     = 1'b1;
                resp_cyc = t + lat_ref(int'(pop[g]));
                exp_data = alu_ref(int'(p1[g]), int'(p2[g]), int'(pop[g]));
                exp_id   = g;
                pend[g]  = 1'b0;
            end else if (busy && t >= resp_cyc && bus.rsp_ready) begin
                busy = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                rr_m = (exp_id + 1) % N;
`endif
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
